// File: rtl/mem_req_arbiter_pkg.sv
// Shared types and constants for the two-master SRAM-like request arbiter.
// Round-robin arbitration is enabled by defining ARB_ROUND_ROBIN_EN.
package mem_req_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOCK_I = 2'd1,
      LOCK_D = 2'd2
   } arb_state_t;

   localparam logic SRC_INST = 1'b0;
   localparam logic SRC_DATA = 1'b1;

   localparam logic [1:0] SIZE_1B = 2'd0;
   localparam logic [1:0] SIZE_2B = 2'd1;
   localparam logic [1:0] SIZE_4B = 2'd2;

endpackage

// File: rtl/mem_req_arbiter_order_fifo.sv
// 1-bit order queue recording which master owns each in-flight request.
// Depth must be a power of two so the pointers wrap naturally.
module arb_order_fifo #(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  logic din,
   input  logic pop,
   output logic dout,
   output logic full,
   output logic empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DEPTH-1:0] mem;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             wr_en;
   logic             rd_en;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign wr_en = push & ~full;
   assign rd_en = pop & ~empty;
   assign dout  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         unique case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates inst/data SRAM-like masters onto one downstream port.
// Define ARB_ROUND_ROBIN_EN for round-robin instead of fixed data priority.
module mem_req_arbiter
   import mem_req_arbiter_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_sram_req,
   input  logic        inst_sram_wr,
   input  logic [1:0]  inst_sram_size,
   input  logic [3:0]  inst_sram_wstrb,
   input  logic [31:0] inst_sram_addr,
   input  logic [31:0] inst_sram_wdata,
   output logic        inst_sram_addr_ok,
   output logic        inst_sram_data_ok,
   output logic [31:0] inst_sram_rdata,
   input  logic        data_sram_req,
   input  logic        data_sram_wr,
   input  logic [1:0]  data_sram_size,
   input  logic [3:0]  data_sram_wstrb,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic        data_sram_addr_ok,
   output logic        data_sram_data_ok,
   output logic [31:0] data_sram_rdata,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata
);

   arb_state_t state;
   logic       pick;
   logic       grant;
   logic       gnt_req;
   logic       hs;
   logic       pop;
   logic       head;
   logic       full;
   logic       empty;

`ifdef ARB_ROUND_ROBIN_EN
   logic prio;

   always_comb begin
      pick = SRC_INST;
      if (data_sram_req & inst_sram_req) pick = prio;
      else if (data_sram_req)            pick = SRC_DATA;
   end

   // Favour whichever master lost the most recent handshake.
   always_ff @(posedge clk) begin
      if (reset)   prio <= SRC_DATA;
      else if (hs) prio <= ~grant;
   end
`else
   always_comb begin
      pick = SRC_INST;
      if (data_sram_req) pick = SRC_DATA;
   end
`endif

   always_comb begin
      grant = pick;
      unique case (state)
         LOCK_I:  grant = SRC_INST;
         LOCK_D:  grant = SRC_DATA;
         default: grant = pick;
      endcase
   end

   assign gnt_req = (grant == SRC_DATA) ? data_sram_req : inst_sram_req;
   assign mem_req = gnt_req & ~full & ~reset;
   assign hs      = mem_req & mem_addr_ok;

   assign mem_wr    = (grant == SRC_DATA) ? data_sram_wr    : inst_sram_wr;
   assign mem_size  = (grant == SRC_DATA) ? data_sram_size  : inst_sram_size;
   assign mem_wstrb = (grant == SRC_DATA) ? data_sram_wstrb : inst_sram_wstrb;
   assign mem_addr  = (grant == SRC_DATA) ? data_sram_addr  : inst_sram_addr;
   assign mem_wdata = (grant == SRC_DATA) ? data_sram_wdata : inst_sram_wdata;

   assign inst_sram_addr_ok = hs & (grant == SRC_INST);
   assign data_sram_addr_ok = hs & (grant == SRC_DATA);

   assign pop = mem_data_ok & ~empty & ~reset;

   assign inst_sram_data_ok = pop & (head == SRC_INST);
   assign data_sram_data_ok = pop & (head == SRC_DATA);
   assign inst_sram_rdata   = mem_rdata;
   assign data_sram_rdata   = mem_rdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (mem_req & ~mem_addr_ok)
                  state <= (grant == SRC_DATA) ? LOCK_D : LOCK_I;
            end
            LOCK_I, LOCK_D: begin
               if (hs | ~gnt_req) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   arb_order_fifo #(
      .DEPTH(MAX_OUTSTANDING)
   ) u_order_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (hs),
      .din   (grant),
      .pop   (pop),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter with a queue-based reference model.
// Honours ARB_ROUND_ROBIN_EN in the model and in the alternation checks.
module tb_mem_req_arbiter;

   localparam int MAXO = 4;
`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_sram_req, inst_sram_wr;
   logic [1:0]  inst_sram_size;
   logic [3:0]  inst_sram_wstrb;
   logic [31:0] inst_sram_addr, inst_sram_wdata;
   logic        inst_sram_addr_ok, inst_sram_data_ok;
   logic [31:0] inst_sram_rdata;
   logic        data_sram_req, data_sram_wr;
   logic [1:0]  data_sram_size;
   logic [3:0]  data_sram_wstrb;
   logic [31:0] data_sram_addr, data_sram_wdata;
   logic        data_sram_addr_ok, data_sram_data_ok;
   logic [31:0] data_sram_rdata;
   logic        mem_req, mem_wr;
   logic [1:0]  mem_size;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_addr_ok, mem_data_ok;
   logic [31:0] mem_rdata;

   int checks = 0;
   int failures = 0;

   mem_req_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
      .clk               (clk),
      .reset             (reset),
      .inst_sram_req     (inst_sram_req),
      .inst_sram_wr      (inst_sram_wr),
      .inst_sram_size    (inst_sram_size),
      .inst_sram_wstrb   (inst_sram_wstrb),
      .inst_sram_addr    (inst_sram_addr),
      .inst_sram_wdata   (inst_sram_wdata),
      .inst_sram_addr_ok (inst_sram_addr_ok),
      .inst_sram_data_ok (inst_sram_data_ok),
      .inst_sram_rdata   (inst_sram_rdata),
      .data_sram_req     (data_sram_req),
      .data_sram_wr      (data_sram_wr),
      .data_sram_size    (data_sram_size),
      .data_sram_wstrb   (data_sram_wstrb),
      .data_sram_addr    (data_sram_addr),
      .data_sram_wdata   (data_sram_wdata),
      .data_sram_addr_ok (data_sram_addr_ok),
      .data_sram_data_ok (data_sram_data_ok),
      .data_sram_rdata   (data_sram_rdata),
      .mem_req           (mem_req),
      .mem_wr            (mem_wr),
      .mem_size          (mem_size),
      .mem_wstrb         (mem_wstrb),
      .mem_addr          (mem_addr),
      .mem_wdata         (mem_wdata),
      .mem_addr_ok       (mem_addr_ok),
      .mem_data_ok       (mem_data_ok),
      .mem_rdata         (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference model: owner queue, lock owner (0 none, 1 inst, 2 data),
   // favoured master for round-robin.
   bit q[$];
   int lock;
   bit fav;

   always @(negedge clk) begin : model
      bit g, greq, full, er, hs, pop, head;
      if (reset) begin
         chk("m_rst_mem_req", mem_req, 0);
         chk("m_rst_i_aok", inst_sram_addr_ok, 0);
         chk("m_rst_d_aok", data_sram_addr_ok, 0);
         chk("m_rst_i_dok", inst_sram_data_ok, 0);
         chk("m_rst_d_dok", data_sram_data_ok, 0);
         q.delete();
         lock = 0;
         fav = 1'b1;
      end else begin
         if (lock == 1) g = 1'b0;
         else if (lock == 2) g = 1'b1;
         else if (data_sram_req && inst_sram_req) g = RR ? fav : 1'b1;
         else g = data_sram_req;
         greq = g ? data_sram_req : inst_sram_req;
         full = (q.size() >= MAXO);
         er = greq && !full;
         hs = er && mem_addr_ok;
         pop = mem_data_ok && (q.size() != 0);
         head = (q.size() != 0) ? q[0] : 1'b0;
         chk("m_mem_req", mem_req, er);
         chk("m_i_aok", inst_sram_addr_ok, hs && !g);
         chk("m_d_aok", data_sram_addr_ok, hs && g);
         chk("m_i_dok", inst_sram_data_ok, pop && !head);
         chk("m_d_dok", data_sram_data_ok, pop && head);
         chk("m_i_rdata", inst_sram_rdata, mem_rdata);
         chk("m_d_rdata", data_sram_rdata, mem_rdata);
         if (er) begin
            chk("m_addr", mem_addr, g ? data_sram_addr : inst_sram_addr);
            chk("m_wdata", mem_wdata, g ? data_sram_wdata : inst_sram_wdata);
            chk("m_wr", mem_wr, g ? data_sram_wr : inst_sram_wr);
            chk("m_size", mem_size, g ? data_sram_size : inst_sram_size);
            chk("m_wstrb", mem_wstrb, g ? data_sram_wstrb : inst_sram_wstrb);
         end
         if (pop) void'(q.pop_front());
         if (hs) q.push_back(g);
         if (lock != 0) begin
            if (hs || !greq) lock = 0;
         end else if (er && !hs) begin
            lock = g ? 2 : 1;
         end
         if (hs) fav = !g;
      end
   end

   task automatic idle_in();
      inst_sram_req = 1'b0;
      data_sram_req = 1'b0;
      mem_addr_ok   = 1'b0;
      mem_data_ok   = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic expd;
      reset = 1'b1;
      idle_in();
      inst_sram_wr = 1'b0;
      inst_sram_size = 2'd2;
      inst_sram_wstrb = 4'h0;
      inst_sram_addr = 32'h1C000000;
      inst_sram_wdata = 32'h0;
      data_sram_wr = 1'b1;
      data_sram_size = 2'd1;
      data_sram_wstrb = 4'b0011;
      data_sram_addr = 32'h00001000;
      data_sram_wdata = 32'hDEADBEEF;
      mem_rdata = 32'h0;

      inst_sram_req = 1'b1;
      mem_addr_ok = 1'b1;
      mem_data_ok = 1'b1;
      tick();
      #1;
      chk("reset_mem_req", mem_req, 0);
      chk("reset_i_aok", inst_sram_addr_ok, 0);
      chk("reset_i_dok", inst_sram_data_ok, 0);
      tick();
      reset = 1'b0;
      idle_in();

      tick();
      inst_sram_req = 1'b1;
      data_sram_req = 1'b1;
      mem_addr_ok = 1'b1;
      #1;
      chk("both_first_addr", mem_addr, 32'h00001000);
      chk("both_first_d_aok", data_sram_addr_ok, 1);
      chk("both_first_i_aok", inst_sram_addr_ok, 0);
      tick();
      data_sram_req = 1'b0;
      #1;
      chk("both_second_addr", mem_addr, 32'h1C000000);
      chk("both_second_i_aok", inst_sram_addr_ok, 1);
      tick();
      idle_in();
      mem_data_ok = 1'b1;
      mem_rdata = 32'hAAAA0001;
      #1;
      chk("resp1_d_dok", data_sram_data_ok, 1);
      chk("resp1_i_dok", inst_sram_data_ok, 0);
      chk("resp1_rdata", data_sram_rdata, 32'hAAAA0001);
      tick();
      mem_rdata = 32'hBBBB0002;
      #1;
      chk("resp2_i_dok", inst_sram_data_ok, 1);
      chk("resp2_d_dok", data_sram_data_ok, 0);
      chk("resp2_rdata", inst_sram_rdata, 32'hBBBB0002);

      tick();
      mem_rdata = 32'h0;
      #1;
      chk("empty_i_dok", inst_sram_data_ok, 0);
      chk("empty_d_dok", data_sram_data_ok, 0);

      tick();
      idle_in();
      inst_sram_req = 1'b1;
      #1;
      chk("lock_c1_mem_req", mem_req, 1);
      chk("lock_c1_i_aok", inst_sram_addr_ok, 0);
      tick();
      data_sram_req = 1'b1;
      #1;
      chk("lock_c2_addr", mem_addr, 32'h1C000000);
      chk("lock_c2_d_aok", data_sram_addr_ok, 0);
      tick();
      #1;
      chk("lock_c3_addr", mem_addr, 32'h1C000000);
      tick();
      mem_addr_ok = 1'b1;
      #1;
      chk("lock_hs_i_aok", inst_sram_addr_ok, 1);
      chk("lock_hs_d_aok", data_sram_addr_ok, 0);
      tick();
      inst_sram_req = 1'b0;
      #1;
      chk("after_lock_d_aok", data_sram_addr_ok, 1);
      chk("after_lock_addr", mem_addr, 32'h00001000);
      tick();
      idle_in();
      mem_data_ok = 1'b1;
      #1;
      chk("lock_resp_i_dok", inst_sram_data_ok, 1);
      tick();
      #1;
      chk("lock_resp_d_dok", data_sram_data_ok, 1);

      tick();
      idle_in();
      inst_sram_req = 1'b1;
      mem_addr_ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         inst_sram_addr = 32'h1C000000 + 32'(i * 4);
         #1;
         chk("fill_i_aok", inst_sram_addr_ok, 1);
         tick();
      end
      #1;
      chk("full_mem_req", mem_req, 0);
      chk("full_i_aok", inst_sram_addr_ok, 0);
      tick();
      mem_data_ok = 1'b1;
      #1;
      chk("full_pop_mem_req", mem_req, 0);
      chk("full_pop_i_dok", inst_sram_data_ok, 1);
      tick();
      mem_data_ok = 1'b0;
      #1;
      chk("after_pop_mem_req", mem_req, 1);
      chk("after_pop_i_aok", inst_sram_addr_ok, 1);
      tick();
      idle_in();
      mem_data_ok = 1'b1;
      repeat (4) tick();

      idle_in();
      inst_sram_addr = 32'h1C000040;
      inst_sram_req = 1'b1;
      tick();
      inst_sram_req = 1'b0;
      data_sram_req = 1'b1;
      tick();
      mem_addr_ok = 1'b1;
      #1;
      chk("cancel_d_aok", data_sram_addr_ok, 1);
      tick();
      idle_in();
      mem_data_ok = 1'b1;
      tick();
      idle_in();

      tick();
      inst_sram_req = 1'b1;
      mem_addr_ok = 1'b1;
      tick();
      tick();
      reset = 1'b1;
      idle_in();
      tick();
      reset = 1'b0;
      mem_data_ok = 1'b1;
      #1;
      chk("stray_i_dok", inst_sram_data_ok, 0);
      chk("stray_d_dok", data_sram_data_ok, 0);

      tick();
      idle_in();
      inst_sram_req = 1'b1;
      data_sram_req = 1'b1;
      mem_addr_ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         expd = RR ? ((i % 2) == 0) : 1'b1;
         #1;
         chk("rr_d_aok", data_sram_addr_ok, expd);
         chk("rr_i_aok", inst_sram_addr_ok, !expd);
         tick();
      end
      #1;
      chk("rr_full_mem_req", mem_req, 0);
      tick();
      idle_in();
      mem_data_ok = 1'b1;
      repeat (4) tick();
      idle_in();
      tick();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
